hdmi_log_packetizer: RTL

Consumes 40-bit capture words (four 10-bit TMDS symbols, oldest symbol in bits [39:30]) from the HDMI channel's capture FIFO read port and frames them into a byte stream for the host-link (USB) transmit path. Each packet is a 4-byte header followed by a fixed number of words, with each word sent as 5 bytes. The block sits on the log clock domain, directly downstream of the capture FIFO and upstream of the USB byte sink.

---
 rtl/hdmi_log_packetizer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hdmi_log_packetizer.sv
// Frames 40-bit capture words from the HDMI capture FIFO into a byte stream:
// a 4-byte header (A5 5A seq count) followed by 5 bytes per word, MSB first.
module hdmi_log_packetizer #(
    parameter int unsigned WORDS_PER_PACKET = 16
) (
    input  logic        log_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        log_empty,
    output logic        log_read,
    input  logic [39:0] log_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [7:0]  seq
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StHdr   = 3'd1;
    localparam logic [2:0] StFetch = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StData  = 3'd4;

    localparam logic [7:0] WordsCfg = 8'(WORDS_PER_PACKET);

    logic [2:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [39:0] word_q, word_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [7:0]  seq_q, seq_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        wcnt_d    = wcnt_q;
        seq_d     = seq_q;
        log_read  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;

        case (state_q)
            StIdle: begin
                if (enable && !log_empty) begin
                    state_d = StHdr;
                    idx_d   = 3'd0;
                    wcnt_d  = 8'd0;
                end
            end
            StHdr: begin
                out_valid = 1'b1;
                case (idx_q)
                    3'd0:    out_data = 8'hA5;
                    3'd1:    out_data = 8'h5A;
                    3'd2:    out_data = seq_q;
                    default: out_data = WordsCfg;
                endcase
                if (out_ready) begin
                    if (idx_q == 3'd3) begin
                        state_d = StFetch;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StFetch: begin
                if (!log_empty) begin
                    log_read = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                // FIFO is in normal mode: read data appears the cycle after log_read.
                word_d  = log_data;
                wcnt_d  = wcnt_q + 8'd1;
                idx_d   = 3'd0;
                state_d = StData;
            end
            StData: begin
                out_valid = 1'b1;
                case (idx_q)
                    3'd0:    out_data = word_q[39:32];
                    3'd1:    out_data = word_q[31:24];
                    3'd2:    out_data = word_q[23:16];
                    3'd3:    out_data = word_q[15:8];
                    default: out_data = word_q[7:0];
                endcase
                if (out_ready) begin
                    if (idx_q == 3'd4) begin
                        idx_d = 3'd0;
                        if (wcnt_q < WordsCfg) begin
                            state_d = StFetch;
                        end else begin
                            seq_d   = seq_q + 8'd1;
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge log_clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            word_q  <= 40'd0;
            wcnt_q  <= 8'd0;
            seq_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            wcnt_q  <= wcnt_d;
            seq_q   <= seq_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign seq  = seq_q;

endmodule
